// File: rtl/mio_pkg.sv
// Shared types and address map for the memory/IO bus controller.
package mio_pkg;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   typedef enum logic [2:0] {RGN_NONE, RGN_RAM, RGN_LED, RGN_SW, RGN_CNT} rgn_e;

   localparam logic [31:0] LED_ADDR = 32'hE000_0000;
   localparam logic [31:0] SW_ADDR  = 32'hF000_0000;
   localparam logic [31:0] CNT_ADDR = 32'hF000_0004;

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side request/response bus between the multi-cycle CPU and the bus controller.
interface mio_bus_ctrl_if;

   logic        cpu_mio;
   logic        mem_w;
   logic [31:0] addr_in;
   logic [31:0] data_from_cpu;
   logic [31:0] data_to_cpu;
   logic        mio_ready;

   modport master (
      output cpu_mio, mem_w, addr_in, data_from_cpu,
      input  data_to_cpu, mio_ready
   );

   modport slave (
      input  cpu_mio, mem_w, addr_in, data_from_cpu,
      output data_to_cpu, mio_ready
   );

endinterface

// File: rtl/mio_addr_decode.sv
// Combinational byte address to region select.
module mio_addr_decode
   import mio_pkg::*;
#(
   parameter int unsigned RAM_AW = 10
) (
   input  logic [31:0] addr_i,
   output rgn_e        rgn_o
);

   always_comb begin
      if (addr_i[31:RAM_AW+2] == '0) begin
         rgn_o = RGN_RAM;
      end else if (addr_i == LED_ADDR) begin
         rgn_o = RGN_LED;
      end else if (addr_i == SW_ADDR) begin
         rgn_o = RGN_SW;
      end else if (addr_i == CNT_ADDR) begin
         rgn_o = RGN_CNT;
      end else begin
         rgn_o = RGN_NONE;
      end
   end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: RAM with wait states, LED register, switch port and
// free-running counter behind a level request / one-cycle ready handshake.
module mio_bus_ctrl
   import mio_pkg::*;
#(
   parameter int unsigned RAM_AW   = 10,
   parameter int unsigned RAM_WAIT = 2,
   parameter int unsigned LED_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   mio_bus_ctrl_if.slave     bus,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   input  logic [15:0]       sw_in,
   output logic [LED_W-1:0]  led_out
);

   localparam logic [3:0] WaitInit = 4'(RAM_WAIT - 1);

   state_e             state_q;
   rgn_e               rgn_q;
   rgn_e               req_rgn;
   logic               we_q;
   logic [31:0]        wdata_q;
   logic [3:0]         wait_q;
   logic               mio_ready_q;
   logic               ram_we_q;
   logic [RAM_AW-1:0]  ram_addr_q;
   logic [31:0]        ram_din_q;
   logic [LED_W-1:0]   led_q;
   logic [31:0]        cnt_q;
   logic [31:0]        rdata;

   // Region is decoded once at acceptance and held for the rest of the access.
   mio_addr_decode #(
      .RAM_AW (RAM_AW)
   ) u_decode (
      .addr_i (bus.addr_in),
      .rgn_o  (req_rgn)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         rgn_q       <= RGN_NONE;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         wait_q      <= '0;
         mio_ready_q <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         led_q       <= '0;
         cnt_q       <= '0;
      end else begin
         cnt_q       <= cnt_q + 32'd1;
         mio_ready_q <= 1'b0;
         ram_we_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.cpu_mio) begin
                  rgn_q      <= req_rgn;
                  we_q       <= bus.mem_w;
                  wdata_q    <= bus.data_from_cpu;
                  ram_addr_q <= bus.addr_in[RAM_AW+1:2];
                  ram_din_q  <= bus.data_from_cpu;
                  if (req_rgn == RGN_RAM) begin
                     state_q <= StWait;
                     wait_q  <= WaitInit;
                  end else begin
                     state_q     <= StDone;
                     mio_ready_q <= 1'b1;
                  end
               end
            end
            StWait: begin
               if (!bus.cpu_mio) begin
                  state_q <= StIdle;
               end else if (wait_q == '0) begin
                  state_q     <= StDone;
                  mio_ready_q <= 1'b1;
                  ram_we_q    <= we_q;
               end else begin
                  wait_q <= wait_q - 4'd1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               if (we_q && rgn_q == RGN_LED) led_q <= wdata_q[LED_W-1:0];
               // Overrides the increment above.
               if (we_q && rgn_q == RGN_CNT) cnt_q <= wdata_q;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      if (state_q == StDone) begin
         unique case (rgn_q)
            RGN_RAM: rdata = ram_dout;
            RGN_LED: rdata = 32'(led_q);
            RGN_SW:  rdata = 32'(sw_in);
            RGN_CNT: rdata = cnt_q;
            default: rdata = '0;
         endcase
      end
   end

   assign bus.data_to_cpu = rdata;
   assign bus.mio_ready   = mio_ready_q;
   assign ram_addr        = ram_addr_q;
   assign ram_we          = ram_we_q;
   assign ram_din         = ram_din_q;
   assign led_out         = led_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed self-checking bench for mio_bus_ctrl with a behavioural 1-cycle RAM.
module tb_mio_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  ram_addr;
   logic        ram_we;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;
   logic [15:0] sw_in;
   logic [7:0]  led_out;

   logic [31:0] mem [0:1023];

   int n_checks = 0;
   int n_pass = 0;
   int n_we = 0;
   int n_rdy = 0;

   logic [31:0] rd;
   int          lat;
   logic        cap_we;
   logic [31:0] cap_addr;
   logic [31:0] cap_din;
   int          base_we;
   int          base_rdy;

   always #5 clk = ~clk;

   mio_bus_ctrl_if bus ();

   mio_bus_ctrl #(
      .RAM_AW   (10),
      .RAM_WAIT (2),
      .LED_W    (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_din  (ram_din),
      .ram_dout (ram_dout),
      .sw_in    (sw_in),
      .led_out  (led_out)
   );

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   always @(posedge clk) begin
      if (ram_we) n_we <= n_we + 1;
      if (bus.mio_ready) n_rdy <= n_rdy + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Issue one access from an IDLE cycle; returns read data and latency in cycles
   // (0 on timeout), then leaves the bench one cycle later, back in IDLE.
   task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdata, output int latency);
      bus.cpu_mio       = 1'b1;
      bus.mem_w         = we;
      bus.addr_in       = a;
      bus.data_from_cpu = d;
      latency = 0;
      rdata   = 'x;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.mio_ready) begin
            latency  = i;
            rdata    = bus.data_to_cpu;
            cap_we   = ram_we;
            cap_addr = 32'(ram_addr);
            cap_din  = ram_din;
            break;
         end
      end
      bus.cpu_mio = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.cpu_mio       = 1'b0;
      bus.mem_w         = 1'b0;
      bus.addr_in       = '0;
      bus.data_from_cpu = '0;
      sw_in             = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst_led", 32'(led_out), 32'h0);
      check("rst_ready", 32'(bus.mio_ready), 32'h0);
      check("rst_rdata", bus.data_to_cpu, 32'h0);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      check("rst_ram_addr", 32'(ram_addr), 32'h0);
      check("rst_ram_din", ram_din, 32'h0);

      xfer(1'b0, 32'hF000_0004, 32'h0, rd, lat);
      check("cnt_first_rd", rd, 32'h1);
      check("cnt_first_lat", 32'(lat), 32'd1);

      xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat);
      check("ramw_lat", 32'(lat), 32'd3);
      check("ramw_we", 32'(cap_we), 32'h1);
      check("ramw_addr", cap_addr, 32'h4);
      check("ramw_din", cap_din, 32'hDEAD_BEEF);
      check("ramw_pulses", 32'(n_we), 32'd1);

      xfer(1'b0, 32'h0000_0010, 32'h0, rd, lat);
      check("ramr_lat", 32'(lat), 32'd3);
      check("ramr_data", rd, 32'hDEAD_BEEF);
      check("ramr_no_we", 32'(n_we), 32'd1);

      xfer(1'b1, 32'h0000_0FFC, 32'h1234_5678, rd, lat);
      check("ram_top_addr", cap_addr, 32'h3FF);
      check("ram_top_lat", 32'(lat), 32'd3);
      xfer(1'b0, 32'h0000_1000, 32'h0, rd, lat);
      check("ram_past_end_rd", rd, 32'h0);
      check("ram_past_end_lat", 32'(lat), 32'd1);

      xfer(1'b1, 32'hE000_0000, 32'h0000_01A5, rd, lat);
      check("ledw_lat", 32'(lat), 32'd1);
      check("ledw_val", 32'(led_out), 32'hA5);
      xfer(1'b0, 32'hE000_0000, 32'h0, rd, lat);
      check("ledr_data", rd, 32'h0000_00A5);

      sw_in = 16'h1234;
      xfer(1'b0, 32'hF000_0000, 32'h0, rd, lat);
      check("swr_data", rd, 32'h0000_1234);
      check("swr_lat", 32'(lat), 32'd1);
      xfer(1'b1, 32'hF000_0000, 32'h0000_FFFF, rd, lat);
      check("sww_lat", 32'(lat), 32'd1);
      check("sww_led_kept", 32'(led_out), 32'hA5);
      xfer(1'b0, 32'h8000_0000, 32'h0, rd, lat);
      check("unmap_rd", rd, 32'h0);
      check("unmap_lat", 32'(lat), 32'd1);
      xfer(1'b1, 32'h8000_0000, 32'h5555_5555, rd, lat);
      check("unmapw_lat", 32'(lat), 32'd1);
      check("unmapw_led_kept", 32'(led_out), 32'hA5);
      check("unmapw_no_we", 32'(n_we), 32'd2);

      // Counter wrap: each following read lands two cycles after the previous one.
      xfer(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, rd, lat);
      check("cntw_lat", 32'(lat), 32'd1);
      xfer(1'b0, 32'hF000_0004, 32'h0, rd, lat);
      check("cnt_rd0", rd, 32'hFFFF_FFFF);
      xfer(1'b0, 32'hF000_0004, 32'h0, rd, lat);
      check("cnt_rd1", rd, 32'h0000_0001);
      xfer(1'b0, 32'hF000_0004, 32'h0, rd, lat);
      check("cnt_rd2", rd, 32'h0000_0003);

      xfer(1'b1, 32'h0000_0020, 32'h1111_1111, rd, lat);
      check("pre_abort_lat", 32'(lat), 32'd3);

      // Drop the request in the first WAIT cycle.
      base_we  = n_we;
      base_rdy = n_rdy;
      bus.cpu_mio       = 1'b1;
      bus.mem_w         = 1'b1;
      bus.addr_in       = 32'h0000_0020;
      bus.data_from_cpu = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      bus.cpu_mio = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_we", 32'(n_we), 32'(base_we));
      check("abort_no_rdy", 32'(n_rdy), 32'(base_rdy));

      // Reset asserted during WAIT.
      bus.cpu_mio = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset       = 1'b0;
      bus.cpu_mio = 1'b0;
      check("rstwait_ready", 32'(bus.mio_ready), 32'h0);
      check("rstwait_led", 32'(led_out), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("rstwait_no_we", 32'(n_we), 32'(base_we));
      check("rstwait_no_rdy", 32'(n_rdy), 32'(base_rdy));

      xfer(1'b0, 32'h0000_0020, 32'h0, rd, lat);
      check("ram_kept_data", rd, 32'h1111_1111);
      check("ram_kept_lat", 32'(lat), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
